// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst read/write request controller for a single-port synchronous RAM
// RAM pins are posedge-registered; read data returns through a 2-entry response FIFO.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_ptr;
  logic [LEN_WIDTH:0]    r_beats_left;
  logic                  r_inflight;
  logic                  r_infl_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_rd_idx;
  logic                  r_wr_idx;
  logic [1:0]            r_count;

  logic       w_req_hs;
  logic       w_wr_hs;
  logic       w_issue;
  logic       w_last_beat;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;

  assign w_req_hs    = req_valid && req_ready;
  assign w_wr_hs     = wdata_valid && wdata_ready;
  assign w_last_beat = (r_beats_left == (LEN_WIDTH+1)'(1));
  assign w_pop       = (r_count != 2'd0) && rsp_ready;
  assign w_push      = r_inflight;
  // Occupancy seen after this edge's pop; at most one slot may be claimed ahead of the FIFO.
  assign w_occ       = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_hs) w_state_nxt = req_we ? S_WR : S_RD;
      S_WR:   if (w_wr_hs && w_last_beat) w_state_nxt = S_IDLE;
      S_RD:   if (w_issue && w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: req_ready   = 1'b1;
      S_WR:   wdata_ready = 1'b1;
      S_RD:   w_issue     = (w_occ <= 3'd1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_ptr   <= '0;
      r_beats_left <= '0;
    end else if (w_req_hs) begin
      r_addr_ptr   <= req_addr;
      r_beats_left <= {1'b0, req_len} + (LEN_WIDTH+1)'(1);
    end else if (w_wr_hs || w_issue) begin
      r_addr_ptr   <= r_addr_ptr + ADDR_WIDTH'(1);
      r_beats_left <= r_beats_left - (LEN_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      mem_data_in <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
    end else begin
      mem_cs <= w_wr_hs || w_issue;
      mem_we <= w_wr_hs;
      mem_oe <= w_issue;
      if (w_wr_hs || w_issue) mem_address <= r_addr_ptr;
      if (w_wr_hs)            mem_data_in <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_infl_last <= w_last_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_rd_idx       <= 1'b0;
      r_wr_idx       <= 1'b0;
      r_count        <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_idx] <= mem_data_out;
        r_fifo_last[r_wr_idx] <= r_infl_last;
        r_wr_idx              <= ~r_wr_idx;
      end
      if (w_pop) r_rd_idx <= ~r_rd_idx;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign rsp_valid = (r_count != 2'd0);
  assign rsp_rdata = r_fifo_data[r_rd_idx];
  assign rsp_last  = r_fifo_last[r_rd_idx];
  assign busy      = (r_state != S_IDLE) || r_inflight || (r_count != 2'd0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - randomized bench for ram_burst_ctrl against a queue-based reference model
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [15:0] wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic        busy;
  logic [7:0]  mem_address;
  logic [15:0] mem_data_in;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic [15:0] mem_data_out;

  ram_burst_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .busy(busy),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM: samples pins on negedge; contents preloaded once and survive reset.
  logic [15:0] ram [256];
  bit          ram_inited = 1'b0;
  always @(negedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h5000 + 16'(i);
      ram_inited <= 1'b1;
    end else begin
      if (mem_cs && mem_we) ram[mem_address] <= mem_data_in;
      if (mem_cs && mem_oe) mem_data_out <= ram[mem_address];
    end
  end

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  // Reference model: mode 0 idle, 1 write burst, 2 read burst.
  int          m_mode;
  logic [7:0]  m_ptr;
  int          m_left;
  beat_t       m_fifo [$];
  bit          m_infl;
  beat_t       m_infl_beat;
  beat_t       m_log [$];
  int          m_log_cyc [$];
  logic        e_cs, e_we, e_oe;
  logic [7:0]  e_addr;
  logic [15:0] e_din;
  logic [15:0] ref_mem [256];
  bit          ref_inited = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          mp_pop, mp_issue;
  beat_t       mp_nb;
  int          mp_occ;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!ref_inited) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h5000 + 16'(i);
        ref_inited = 1'b1;
      end
      m_mode = 0; m_fifo.delete(); m_infl = 1'b0;
      e_cs = 1'b0; e_we = 1'b0; e_oe = 1'b0; e_addr = '0; e_din = '0;
    end else begin
      cyc++;
      mp_pop = (m_fifo.size() != 0) && rsp_ready;
      mp_issue = 1'b0;
      e_cs = 1'b0; e_we = 1'b0; e_oe = 1'b0;
      case (m_mode)
        0: if (req_valid) begin
          m_ptr = req_addr; m_left = int'(req_len) + 1;
          m_mode = req_we ? 1 : 2; acc_cyc = cyc;
        end
        1: if (wdata_valid) begin
          e_cs = 1'b1; e_we = 1'b1; e_addr = m_ptr; e_din = wdata;
          ref_mem[m_ptr] = wdata;
          m_ptr = m_ptr + 8'd1; m_left--;
          if (m_left == 0) m_mode = 0;
        end
        2: begin
          mp_occ = int'(m_fifo.size()) + (m_infl ? 1 : 0) - (mp_pop ? 1 : 0);
          if (mp_occ <= 1) begin
            mp_issue = 1'b1; e_cs = 1'b1; e_oe = 1'b1; e_addr = m_ptr;
            mp_nb.d = ref_mem[m_ptr]; mp_nb.l = (m_left == 1);
            m_ptr = m_ptr + 8'd1; m_left--;
            if (m_left == 0) m_mode = 0;
          end
        end
        default: ;
      endcase
      if (mp_pop) begin
        m_log.push_back(m_fifo.pop_front());
        m_log_cyc.push_back(cyc);
      end
      if (m_infl) m_fifo.push_back(m_infl_beat);
      m_infl = mp_issue;
      if (mp_issue) m_infl_beat = mp_nb;
    end
  end

  int          total = 0;
  int          bad = 0;
  bit          rr_rand = 1'b0;
  logic [7:0]  wlog [$];
  int          wcyc [$];
  int          rcyc [$];
  logic [15:0] wbuf [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every wait goes through here, so DUT outputs are compared against the model each cycle.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("req_ready", req_ready, m_mode == 0);
      chk("wdata_ready", wdata_ready, m_mode == 1);
      chk("rsp_valid", rsp_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
        chk("rsp_rdata", rsp_rdata, m_fifo[0].d);
        chk("rsp_last", rsp_last, m_fifo[0].l);
      end
      chk("busy", busy, (m_mode != 0) || m_infl || (m_fifo.size() != 0));
      chk("mem_cs", mem_cs, e_cs);
      chk("mem_we", mem_we, e_we);
      chk("mem_oe", mem_oe, e_oe);
      chk("mem_address", mem_address, e_addr);
      chk("mem_data_in", mem_data_in, e_din);
      if (mem_cs && mem_we) begin wlog.push_back(mem_address); wcyc.push_back(cyc); end
      if (mem_cs && mem_oe) rcyc.push_back(cyc);
    end
    if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_req(input logic we, input logic [7:0] a, input logic [3:0] l);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("req_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // gap: 0 = always valid, 1 = pattern 1,0,0,1,1 then valid, 2 = random
  task automatic write_burst(input logic [7:0] a, input logic [3:0] l, input int gap);
    int i = 0;
    int k = 0;
    logic [4:0] pat;
    logic v;
    pat = 5'b11001;
    send_req(1'b1, a, l);
    while (i <= int'(l) && k < 500) begin
      if (gap == 0)      v = 1'b1;
      else if (gap == 1) v = (k < 5) ? pat[k] : 1'b1;
      else               v = ($urandom_range(0, 2) != 0);
      wdata_valid = v; wdata = wbuf[i];
      if (v && wdata_ready) i++;
      tick(); k++;
    end
    if (k >= 500) chk("wdata_timeout", 0, 1);
    wdata_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [3:0] l, input int lo_from,
                            input int lo_n, input bit wait_done);
    int n = 0;
    send_req(1'b0, a, l);
    if (wait_done) begin
      while (busy && n < 400) begin
        if (!rr_rand) rsp_ready = !(n >= lo_from && n < lo_from + lo_n);
        tick(); n++;
      end
      if (n >= 400) chk("drain_timeout", 0, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, w0, r0, acc;
    repeat (3) @(negedge clk);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_oe", mem_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_mem_address", mem_address, 0);
    rst_n = 1'b1;
    tick();

    // Write 0x10..0x17 = 0xA000..0xA007 (first burst is the len=3 plan case)
    for (int i = 0; i < 4; i++) wbuf[i] = 16'hA000 + 16'(i);
    w0 = wlog.size();
    write_burst(8'h10, 4'd3, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr1_addr", wlog[w0+i], 8'h10 + 8'(i));
      chk("wr1_ram", ram[8'h10 + 8'(i)], 16'hA000 + 16'(i));
    end
    chk("wr1_consecutive", wcyc[w0+3] - wcyc[w0], 3);
    for (int i = 0; i < 4; i++) wbuf[i] = 16'hA004 + 16'(i);
    write_burst(8'h14, 4'd3, 0);

    // Read 0x10 len=3 with rsp_ready held high
    rr_rand = 1'b0; rsp_ready = 1'b1;
    l0 = m_log.size();
    read_burst(8'h10, 4'd3, 0, 0, 1'b1);
    acc = acc_cyc;
    chk("rd1_count", m_log.size() - l0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rd1_data", m_log[l0+i].d, 16'hA000 + 16'(i));
      chk("rd1_last", m_log[l0+i].l, i == 3);
      chk("rd1_timing", m_log_cyc[l0+i] - acc, 3 + i);
    end

    // Read 0x10 len=7 with rsp_ready low for 5 cycles: issue stalls until room returns
    l0 = m_log.size(); r0 = rcyc.size();
    read_burst(8'h10, 4'd7, 2, 5, 1'b1);
    acc = acc_cyc;
    chk("rd2_count", m_log.size() - l0, 8);
    chk("rd2_issues", rcyc.size() - r0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("rd2_data", m_log[l0+i].d, 16'hA000 + 16'(i));
      chk("rd2_last", m_log[l0+i].l, i == 7);
    end
    chk("rd2_first_issue", rcyc[r0] - acc, 1);
    chk("rd2_last_issue", rcyc[r0+7] - acc, 13);

    // Address wrap 0xFE -> 0xFF -> 0x00
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    w0 = wlog.size();
    write_burst(8'hFE, 4'd2, 0);
    chk("wrap_a0", wlog[w0], 8'hFE);
    chk("wrap_a1", wlog[w0+1], 8'hFF);
    chk("wrap_a2", wlog[w0+2], 8'h00);
    rsp_ready = 1'b1;
    l0 = m_log.size();
    read_burst(8'hFE, 4'd2, 0, 0, 1'b1);
    chk("wrap_rd0", m_log[l0].d, 16'h1111);
    chk("wrap_rd1", m_log[l0+1].d, 16'h2222);
    chk("wrap_rd2", m_log[l0+2].d, 16'h3333);
    chk("wrap_rd_last", m_log[l0+2].l, 1);

    // Gapped write data: 1,0,0,1,1
    for (int i = 0; i < 3; i++) wbuf[i] = 16'hB000 + 16'(i);
    w0 = wlog.size();
    write_burst(8'h30, 4'd2, 1);
    chk("gap_req_ready", req_ready, 1);
    tick();
    chk("gap_writes", wlog.size() - w0, 3);
    chk("gap_spacing", wcyc[w0+1] - wcyc[w0], 3);
    chk("gap_ram", ram[8'h32], 16'hB002);

    // Reset with one beat in the FIFO and one in flight
    rsp_ready = 1'b0;
    send_req(1'b0, 8'h10, 4'd7);
    tick();
    tick();
    chk("pre_rst_fifo", m_fifo.size(), 1);
    chk("pre_rst_infl", m_infl, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_mem_cs", mem_cs, 0);
    chk("mid_rst_mem_oe", mem_oe, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    l0 = m_log.size();
    read_burst(8'h12, 4'd0, 0, 0, 1'b1);
    chk("post_rst_count", m_log.size() - l0, 1);
    chk("post_rst_data", m_log[l0].d, 16'hA002);
    chk("post_rst_last", m_log[l0].l, 1);

    // Randomized traffic
    rr_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [7:0] a;
      logic [3:0] l;
      a = 8'($urandom_range(8'h20, 8'hDF));
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
        write_burst(a, l, 2);
      end else begin
        read_burst(a, l, 0, 0, $urandom_range(0, 1) == 1);
      end
    end
    begin
      int n = 0;
      while (busy && n < 400) begin tick(); n++; end
      if (n >= 400) chk("final_drain_timeout", 0, 1);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
